// File: rtl/redmule_pkg.sv
// Shared constants, FSM state type and periph payload layout for the RedMulE config master.
package redmule_pkg;

  localparam int unsigned REDMULE_REGS = 6;

  localparam logic [31:0] REDMULE_TRIGGER_OFS = 32'h0000_0000;
  localparam logic [31:0] REDMULE_ACQUIRE_OFS = 32'h0000_0004;
  localparam logic [31:0] REDMULE_SOFTCLR_OFS = 32'h0000_0014;
  localparam logic [31:0] REDMULE_IO_OFS      = 32'h0000_0040;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACQ_REQ,
    ST_ACQ_RSP,
    ST_WR_REGS,
    ST_TRIGGER,
    ST_WAIT_EVT
  } cfg_master_state_e;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [7:0]  be;
    logic [63:0] data;
  } periph_req_t;

  // 32-bit word lives in the upper half of the 64-bit bus when A[2] is set
  function automatic logic [7:0] lane_be(input logic [31:0] addr);
    return addr[2] ? 8'hF0 : 8'h0F;
  endfunction

endpackage

// File: rtl/redmule_periph_txn.sv
// Single outstanding periph transaction driver; valid_i describes the request for the next cycle
// and is only taken when the bus slot is free, so a granted write can be followed back-to-back.
module redmule_periph_txn
  import redmule_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        is_read_i,
  output logic        req_o,
  output logic [31:0] add_o,
  output logic        wen_o,
  output logic [7:0]  be_o,
  output logic [63:0] data_o,
  input  logic        gnt_i,
  input  logic [31:0] rsp_data_i,
  input  logic        r_valid_i,
  output logic        req_done_c,
  output logic        rsp_valid_c,
  output logic [31:0] rsp_word_c
);

  logic        r_req;
  logic        r_wait;
  periph_req_t r_pld;
  periph_req_t w_pld;
  logic [31:0] w_wd;
  logic        w_free;

  always_comb begin
    w_wd       = is_read_i ? 32'h0 : wdata_i;
    w_pld.add  = addr_i;
    w_pld.wen  = is_read_i;
    w_pld.be   = lane_be(addr_i);
    w_pld.data = addr_i[2] ? {w_wd, 32'h0} : {32'h0, w_wd};
  end

  assign req_done_c  = r_req & gnt_i;
  assign rsp_valid_c = r_wait & r_valid_i;
  assign rsp_word_c  = rsp_data_i;

  // Slot frees on a write grant, or on the response of an outstanding read
  assign w_free = r_req ? (gnt_i & ~r_pld.wen) : (r_wait ? r_valid_i : 1'b1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req  <= 1'b0;
      r_wait <= 1'b0;
      r_pld  <= '0;
    end else if (clear_i) begin
      r_req  <= 1'b0;
      r_wait <= 1'b0;
    end else if (w_free && valid_i) begin
      r_req  <= 1'b1;
      r_wait <= 1'b0;
      r_pld  <= w_pld;
    end else begin
      if (req_done_c) begin
        r_req  <= 1'b0;
        r_wait <= r_pld.wen;
      end
      if (rsp_valid_c) r_wait <= 1'b0;
    end
  end

  assign req_o  = r_req;
  assign add_o  = r_pld.add;
  assign wen_o  = r_pld.wen;
  assign be_o   = r_pld.be;
  assign data_o = r_pld.data;

endmodule

// File: rtl/redmule_cfg_master.sv
// Offloads one RedMulE job over the periph port: acquire, write job registers, trigger, await event.
module redmule_cfg_master
  import redmule_pkg::*;
#(
  parameter int unsigned N_REGS        = REDMULE_REGS,
  parameter int unsigned ID_WIDTH      = 8,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned MAX_ACQ_RETRY = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [N_REGS*32-1:0]  job_regs_i,
  input  logic                  soft_clear_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [7:0]            job_id_o,
  output logic                  req_o,
  output logic [31:0]           add_o,
  output logic                  wen_o,
  output logic [7:0]            be_o,
  output logic [63:0]           data_o,
  output logic [ID_WIDTH-1:0]   id_o,
  input  logic                  gnt_i,
  input  logic [63:0]           r_data_i,
  input  logic                  r_valid_i,
  input  logic                  evt_i
);

  localparam int unsigned IDX_W   = $clog2(N_REGS + 1);
  localparam int unsigned RETRY_W = (MAX_ACQ_RETRY < 2) ? 1 : $clog2(MAX_ACQ_RETRY + 1);

  cfg_master_state_e  r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [RETRY_W-1:0] r_retry, w_retry_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_error, w_error_nxt;
  logic [7:0]         r_job_id, w_job_id_nxt;
  logic [31:0]        r_job [N_REGS];
  logic               w_latch;

  logic               w_txn_valid, w_txn_read;
  logic [31:0]        w_txn_addr, w_word;
  logic               w_req_done, w_rsp_valid;
  logic [31:0]        w_rsp_word;
  logic               w_unused;

  assign w_unused = ^{r_data_i[63:32], w_rsp_word[30:8]};
  assign id_o     = '0;

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_retry_nxt  = r_retry;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_error_nxt  = 1'b0;
    w_job_id_nxt = r_job_id;
    w_latch      = 1'b0;
    case (r_state)
      ST_IDLE: if (start_i) begin
        w_latch     = 1'b1;
        w_busy_nxt  = 1'b1;
        w_idx_nxt   = '0;
        w_retry_nxt = '0;
        w_state_nxt = ST_ACQ_REQ;
      end
      ST_ACQ_REQ: if (w_req_done) w_state_nxt = ST_ACQ_RSP;
      ST_ACQ_RSP: if (w_rsp_valid) begin
        if (!w_rsp_word[31]) begin
          w_job_id_nxt = w_rsp_word[7:0];
          w_idx_nxt    = '0;
          w_state_nxt  = ST_WR_REGS;
        end else if ((MAX_ACQ_RETRY != 0) && (32'(r_retry) + 32'd1 == MAX_ACQ_RETRY)) begin
          w_error_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_retry_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_retry_nxt = r_retry + RETRY_W'(1);
          w_state_nxt = ST_ACQ_REQ;
        end
      end
      ST_WR_REGS: if (w_req_done) begin
        w_idx_nxt = r_idx + IDX_W'(1);
        if (r_idx == IDX_W'(N_REGS - 1)) w_state_nxt = ST_TRIGGER;
      end
      ST_TRIGGER: if (w_req_done) w_state_nxt = ST_WAIT_EVT;
      ST_WAIT_EVT: if (evt_i) begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (soft_clear_i) begin
      w_state_nxt = ST_IDLE;
      w_busy_nxt  = 1'b0;
      w_idx_nxt   = '0;
      w_retry_nxt = '0;
      w_done_nxt  = 1'b0;
      w_error_nxt = 1'b0;
      w_latch     = 1'b0;
    end
  end

  // Request the transaction belonging to the state entered next cycle
  always_comb begin
    w_txn_valid = 1'b0;
    w_txn_read  = 1'b0;
    w_txn_addr  = '0;
    w_word      = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (w_idx_nxt == IDX_W'(i)) w_word = r_job[i];
    end
    case (w_state_nxt)
      ST_ACQ_REQ: begin
        w_txn_valid = 1'b1;
        w_txn_read  = 1'b1;
        w_txn_addr  = BASE_ADDR + REDMULE_ACQUIRE_OFS;
      end
      ST_WR_REGS: begin
        w_txn_valid = 1'b1;
        w_txn_addr  = BASE_ADDR + REDMULE_IO_OFS + (32'(w_idx_nxt) << 2);
      end
      ST_TRIGGER: begin
        w_txn_valid = 1'b1;
        w_txn_addr  = BASE_ADDR + REDMULE_TRIGGER_OFS;
        w_word      = 32'h0;
      end
      default: w_txn_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_retry  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_job_id <= '0;
      for (int unsigned i = 0; i < N_REGS; i++) r_job[i] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_retry  <= w_retry_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_error  <= w_error_nxt;
      r_job_id <= w_job_id_nxt;
      if (w_latch) begin
        for (int unsigned i = 0; i < N_REGS; i++) r_job[i] <= job_regs_i[32*i +: 32];
      end
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign error_o  = r_error;
  assign job_id_o = r_job_id;

  redmule_periph_txn u_txn (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (soft_clear_i),
    .valid_i     (w_txn_valid),
    .addr_i      (w_txn_addr),
    .wdata_i     (w_word),
    .is_read_i   (w_txn_read),
    .req_o       (req_o),
    .add_o       (add_o),
    .wen_o       (wen_o),
    .be_o        (be_o),
    .data_o      (data_o),
    .gnt_i       (gnt_i),
    .rsp_data_i  (r_data_i[31:0]),
    .r_valid_i   (r_valid_i),
    .req_done_c  (w_req_done),
    .rsp_valid_c (w_rsp_valid),
    .rsp_word_c  (w_rsp_word)
  );

endmodule

// File: tb/tb_redmule_cfg_master.sv
// Bench for redmule_cfg_master: random periph slave plus a transaction-list model of one offload.
module tb_redmule_cfg_master;

  localparam int          N    = 6;
  localparam logic [31:0] BASE = 32'h1A10_0000;
  localparam int          MAXR = 3;

  logic               clk = 1'b0;
  logic               rst_ni = 1'b0;
  logic               start_i = 1'b0;
  logic [N*32-1:0]    job_regs_i = '0;
  logic               soft_clear_i = 1'b0;
  logic               busy_o, done_o, error_o;
  logic [7:0]         job_id_o;
  logic               req_o;
  logic [31:0]        add_o;
  logic               wen_o;
  logic [7:0]         be_o;
  logic [63:0]        data_o;
  logic [7:0]         id_o;
  logic               gnt_i;
  logic [63:0]        r_data_i;
  logic               r_valid_i;
  logic               evt_i = 1'b0;

  redmule_cfg_master #(.N_REGS(N), .ID_WIDTH(8), .BASE_ADDR(BASE), .MAX_ACQ_RETRY(MAXR)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .job_regs_i(job_regs_i),
    .soft_clear_i(soft_clear_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .job_id_o(job_id_o), .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .be_o(be_o),
    .data_o(data_o), .id_o(id_o), .gnt_i(gnt_i), .r_data_i(r_data_i),
    .r_valid_i(r_valid_i), .evt_i(evt_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] add;
    logic        wen;
    logic [7:0]  be;
    logic [63:0] data;
    int          cyc;
  } txn_t;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic [31:0] acq_q[$];
  logic [31:0] plan_q[$];
  logic [31:0] regs [N];
  int          acq_rd = 0;
  int          done_cnt = 0, err_cnt = 0, stab_viol = 0;
  int          stall_max = 0;
  int          cyc = 0;
  int          checks = 0, errors = 0;
  logic [7:0]  exp_id;
  bit          exp_err;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Periph slave: random grant stalls, 1..3 cycle read latency, acquire words from acq_q
  initial begin
    bit          gnt_q, p_req, p_wen;
    logic [31:0] p_add, w;
    logic [7:0]  p_be;
    logic [63:0] p_data;
    int          rsp_cnt, stall_left;
    txn_t        t;
    gnt_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0;
    gnt_q = 0; p_req = 0; p_wen = 0; p_add = '0; p_be = '0; p_data = '0;
    rsp_cnt = 0; stall_left = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        gnt_i = 1'b0; r_valid_i = 1'b0; rsp_cnt = 0; gnt_q = 0; p_req = 0; stall_left = 0;
      end else begin
        if (p_req && gnt_q) begin
          t.add = p_add; t.wen = p_wen; t.be = p_be; t.data = p_data; t.cyc = cyc;
          log_q.push_back(t);
          if (p_wen) rsp_cnt = $urandom_range(3, 1);
        end else if (p_req && (req_o !== 1'b1 || add_o !== p_add || wen_o !== p_wen ||
                               be_o !== p_be || data_o !== p_data)) begin
          stab_viol++;
        end
        r_valid_i = 1'b0;
        if (rsp_cnt > 0) begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            w = 32'h0;
            if (acq_rd < acq_q.size()) begin
              w = acq_q[acq_rd];
              acq_rd++;
            end
            r_valid_i = 1'b1;
            r_data_i  = {$urandom(), w};
          end
        end
        if (done_o === 1'b1) done_cnt++;
        if (error_o === 1'b1) err_cnt++;
        if (req_o === 1'b1) begin
          if (stall_left > 0) begin
            gnt_i = 1'b0;
            stall_left--;
          end else begin
            gnt_i = 1'b1;
            stall_left = $urandom_range(stall_max, 0);
          end
        end else begin
          gnt_i = 1'b0;
        end
        p_req = req_o; p_add = add_o; p_wen = wen_o; p_be = be_o; p_data = data_o;
        gnt_q = gnt_i;
      end
    end
  end

  function automatic txn_t mk(input logic [31:0] a, input logic rd, input logic [31:0] w);
    txn_t t;
    bit   hi;
    hi     = ((a % 8) == 4);
    t.add  = a;
    t.wen  = rd;
    t.be   = hi ? 8'hF0 : 8'h0F;
    t.data = hi ? {w, 32'h0} : {32'h0, w};
    t.cyc  = 0;
    return t;
  endfunction

  // Expected bus traffic for one job, given the acquire responses in plan_q
  function automatic void build_exp();
    int busy_n;
    bit ok;
    exp_q.delete();
    exp_err = 0; exp_id = '0; busy_n = 0; ok = 0;
    foreach (plan_q[k]) begin
      exp_q.push_back(mk(BASE + 32'h4, 1'b1, 32'h0));
      if (!plan_q[k][31]) begin
        exp_id = plan_q[k][7:0];
        ok = 1;
        break;
      end
      busy_n++;
      if (busy_n == MAXR) begin
        exp_err = 1;
        break;
      end
    end
    if (ok) begin
      for (int i = 0; i < N; i++) exp_q.push_back(mk(BASE + 32'h40 + 32'(4 * i), 1'b0, regs[i]));
      exp_q.push_back(mk(BASE, 1'b0, 32'h0));
    end
  endfunction

  function automatic bit same(input txn_t a, input txn_t b);
    return a.add === b.add && a.wen === b.wen && a.be === b.be && a.data === b.data;
  endfunction

  task automatic start_job();
    for (int i = 0; i < N; i++) job_regs_i[32*i +: 32] = regs[i];
    foreach (plan_q[k]) acq_q.push_back(plan_q[k]);
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (log_q.size() >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic pulse_evt();
    @(negedge clk);
    evt_i = 1'b1;
    @(negedge clk);
    evt_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({req_o, busy_o, done_o, error_o, wen_o} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl got %b want 00000", {req_o, busy_o, done_o, error_o, wen_o}); end
    checks++; if (add_o !== 32'h0) begin errors++; $display("FAIL reset_add got %h want 0", add_o); end
    checks++; if (be_o !== 8'h0) begin errors++; $display("FAIL reset_be got %h want 0", be_o); end
    checks++; if (data_o !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", data_o); end
    checks++; if (job_id_o !== 8'h0) begin errors++; $display("FAIL reset_jobid got %h want 0", job_id_o); end
    @(negedge clk);
    #2 rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_o !== 1'b0 || busy_o !== 1'b0 || id_o !== 8'h0) begin errors++;
      $display("FAIL post_reset_idle got req=%b busy=%b id=%h want 0 0 00", req_o, busy_o, id_o); end
  endtask

  task automatic test_basic();
    int lb, d0;
    bit ok;
    stall_max = 0;
    foreach (regs[i]) regs[i] = $urandom();
    plan_q = '{32'h0000_0001};
    build_exp();
    lb = log_q.size(); d0 = done_cnt;
    start_job();
    wait_log(lb + exp_q.size(), 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got %0d txns want %0d", log_q.size() - lb, exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (lb + i >= log_q.size() || !same(log_q[lb + i], exp_q[i])) begin errors++;
        $display("FAIL basic_txn%0d got add=%h be=%h data=%h want add=%h be=%h data=%h", i,
                 (lb + i < log_q.size()) ? log_q[lb + i].add : 32'hx, (lb + i < log_q.size()) ? log_q[lb + i].be : 8'hx,
                 (lb + i < log_q.size()) ? log_q[lb + i].data : 64'hx, exp_q[i].add, exp_q[i].be, exp_q[i].data); end
    end
    for (int i = 2; i < exp_q.size() && lb + i < log_q.size(); i++) begin
      checks++;
      if (log_q[lb + i].cyc != log_q[lb + i - 1].cyc + 1) begin errors++;
        $display("FAIL basic_b2b%0d got cycle gap %0d want 1", i, log_q[lb + i].cyc - log_q[lb + i - 1].cyc); end
    end
    checks++; if (job_id_o !== 8'h01) begin errors++; $display("FAIL basic_jobid got %h want 01", job_id_o); end
    repeat (50) @(negedge clk);
    checks++; if (busy_o !== 1'b1 || done_cnt != d0) begin errors++;
      $display("FAIL basic_wait got busy=%b dones=%0d want 1 0", busy_o, done_cnt - d0); end
    pulse_evt();
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++;
      $display("FAIL basic_done got done=%b busy=%b want 1 0", done_o, busy_o); end
    @(negedge clk);
    checks++; if (done_o !== 1'b0 || done_cnt != d0 + 1) begin errors++;
      $display("FAIL basic_done_pulse got done=%b count=%0d want 0 1", done_o, done_cnt - d0); end
  endtask

  task automatic test_retry();
    int lb, d0;
    bit ok;
    stall_max = 1;
    foreach (regs[i]) regs[i] = $urandom();
    plan_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    build_exp();
    lb = log_q.size(); d0 = done_cnt;
    start_job();
    wait_log(lb + exp_q.size(), 800, ok);
    checks++; if (!ok || log_q.size() - lb != exp_q.size()) begin errors++;
      $display("FAIL retry_count got %0d txns want %0d", log_q.size() - lb, exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (lb + i >= log_q.size() || !same(log_q[lb + i], exp_q[i])) begin errors++;
        $display("FAIL retry_txn%0d got add=%h want add=%h data=%h", i,
                 (lb + i < log_q.size()) ? log_q[lb + i].add : 32'hx, exp_q[i].add, exp_q[i].data); end
    end
    checks++; if (job_id_o !== 8'h00) begin errors++; $display("FAIL retry_jobid got %h want 00", job_id_o); end
    pulse_evt();
    @(negedge clk);
    checks++; if (done_cnt != d0 + 1 || busy_o !== 1'b0) begin errors++;
      $display("FAIL retry_done got dones=%0d busy=%b want 1 0", done_cnt - d0, busy_o); end
  endtask

  task automatic test_stalls();
    int  lb, d0, s0;
    bit  ok;
    for (int job = 0; job < 3; job++) begin
      stall_max = 5;
      foreach (regs[i]) regs[i] = $urandom();
      plan_q = '{$urandom() & 32'h7FFF_FFFF};
      build_exp();
      lb = log_q.size(); d0 = done_cnt; s0 = stab_viol;
      start_job();
      // a second start while busy must not replace the latched registers
      repeat (3) @(negedge clk);
      job_regs_i = {N{$urandom()}};
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_log(lb + exp_q.size(), 2000, ok);
      checks++; if (!ok || log_q.size() - lb != exp_q.size()) begin errors++;
        $display("FAIL stall%0d_count got %0d txns want %0d", job, log_q.size() - lb, exp_q.size()); end
      foreach (exp_q[i]) begin
        checks++;
        if (lb + i >= log_q.size() || !same(log_q[lb + i], exp_q[i])) begin errors++;
          $display("FAIL stall%0d_txn%0d got add=%h data=%h want add=%h data=%h", job, i,
                   (lb + i < log_q.size()) ? log_q[lb + i].add : 32'hx,
                   (lb + i < log_q.size()) ? log_q[lb + i].data : 64'hx, exp_q[i].add, exp_q[i].data); end
      end
      checks++; if (stab_viol != s0) begin errors++;
        $display("FAIL stall%0d_stable got %0d unstable cycles want 0", job, stab_viol - s0); end
      checks++; if (job_id_o !== exp_id) begin errors++;
        $display("FAIL stall%0d_jobid got %h want %h", job, job_id_o, exp_id); end
      pulse_evt();
      checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin errors++;
        $display("FAIL stall%0d_done got done=%b busy=%b want 1 0", job, done_o, busy_o); end
    end
  endtask

  task automatic test_acq_error();
    int  lb, d0, e0;
    bit  ok;
    stall_max = 2;
    foreach (regs[i]) regs[i] = $urandom();
    plan_q = '{32'hFFFF_FFFF, 32'h8000_0012, 32'hC000_0000};
    build_exp();
    lb = log_q.size(); d0 = done_cnt; e0 = err_cnt;
    start_job();
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (busy_o === 1'b0) begin ok = 1; break; end
    end
    repeat (20) @(negedge clk);
    checks++; if (!ok || !exp_err) begin errors++; $display("FAIL acqerr_busy got busy=%b want 0", busy_o); end
    checks++; if (err_cnt != e0 + 1 || done_cnt != d0) begin errors++;
      $display("FAIL acqerr_pulse got errors=%0d dones=%0d want 1 0", err_cnt - e0, done_cnt - d0); end
    checks++; if (log_q.size() - lb != exp_q.size()) begin errors++;
      $display("FAIL acqerr_count got %0d txns want %0d", log_q.size() - lb, exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (lb + i >= log_q.size() || !same(log_q[lb + i], exp_q[i])) begin errors++;
        $display("FAIL acqerr_txn%0d got add=%h want %h", i,
                 (lb + i < log_q.size()) ? log_q[lb + i].add : 32'hx, exp_q[i].add); end
    end
  endtask

  task automatic test_soft_clear();
    int  lb, d0;
    bit  ok;
    stall_max = 0;
    foreach (regs[i]) regs[i] = $urandom();
    plan_q = '{32'h0000_0005};
    build_exp();
    d0 = done_cnt;
    start_job();
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (req_o === 1'b1 && add_o === BASE + 32'h48) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL sclr_reach got add=%h want %h", add_o, BASE + 32'h48); end
    soft_clear_i = 1'b1;
    @(negedge clk);
    soft_clear_i = 1'b0;
    checks++; if (req_o !== 1'b0 || busy_o !== 1'b0) begin errors++;
      $display("FAIL sclr_idle got req=%b busy=%b want 0 0", req_o, busy_o); end
    pulse_evt();
    repeat (3) @(negedge clk);
    checks++; if (done_cnt != d0 || req_o !== 1'b0) begin errors++;
      $display("FAIL sclr_nodone got dones=%0d req=%b want 0 0", done_cnt - d0, req_o); end
    start_i = 1'b1; soft_clear_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; soft_clear_i = 1'b0;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0 || req_o !== 1'b0) begin errors++;
      $display("FAIL sclr_over_start got busy=%b req=%b want 0 0", busy_o, req_o); end
    plan_q = '{32'h0000_0007};
    build_exp();
    lb = log_q.size();
    start_job();
    wait_log(lb + exp_q.size(), 500, ok);
    foreach (exp_q[i]) begin
      checks++;
      if (lb + i >= log_q.size() || !same(log_q[lb + i], exp_q[i])) begin errors++;
        $display("FAIL sclr_restart_txn%0d got add=%h want %h", i,
                 (lb + i < log_q.size()) ? log_q[lb + i].add : 32'hx, exp_q[i].add); end
    end
    pulse_evt();
    checks++; if (done_o !== 1'b1 || job_id_o !== 8'h07) begin errors++;
      $display("FAIL sclr_restart_done got done=%b id=%h want 1 07", done_o, job_id_o); end
  endtask

  task automatic test_reset_mid();
    int  lb, d0;
    bit  ok;
    stall_max = 0;
    foreach (regs[i]) regs[i] = $urandom();
    plan_q = '{32'h0000_0033};
    build_exp();
    lb = log_q.size();
    start_job();
    wait_log(lb + exp_q.size(), 500, ok);
    checks++; if (!ok || busy_o !== 1'b1) begin errors++;
      $display("FAIL rstmid_reach got busy=%b want 1", busy_o); end
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    checks++; if ({req_o, busy_o, done_o, error_o} !== 4'b0 || job_id_o !== 8'h0 ||
                  add_o !== 32'h0 || be_o !== 8'h0 || data_o !== 64'h0) begin errors++;
      $display("FAIL rstmid_outputs got req=%b busy=%b id=%h add=%h be=%h want all 0",
               req_o, busy_o, job_id_o, add_o, be_o); end
    repeat (2) @(negedge clk);
    #2 rst_ni = 1'b1;
    d0 = done_cnt;
    pulse_evt();
    repeat (3) @(negedge clk);
    checks++; if (done_cnt != d0 || busy_o !== 1'b0 || req_o !== 1'b0) begin errors++;
      $display("FAIL rstmid_evt got dones=%0d busy=%b req=%b want 0 0 0", done_cnt - d0, busy_o, req_o); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_retry();
    test_stalls();
    test_acq_error();
    test_soft_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/redmule_cfg_master.md
Name: redmule_cfg_master

Overview:
- Initiator for the RedMulE peripheral config port: offloads one job to the controller's periph slave and waits for completion.
- Acquires a context, writes N_REGS job registers, writes TRIGGER, then waits for the done event.
- Sits in the cluster-side test/offload path; drives the 64-bit periph bus that the controller narrows to 32 bits.

Parameters:
- N_REGS, REDMULE_REGS, number of job (io) registers written per job.
- ID_WIDTH, 8, periph transaction id width.
- BASE_ADDR, 32'h0000_0000, byte base address of the RedMulE config space.
- MAX_ACQ_RETRY, 255, acquire polls before error; 0 means unlimited.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- start_i  in  1  pulse; latch job_regs_i and begin offload
- job_regs_i  in  N_REGS*32  job register values; word i in bits [32i+31:32i]
- soft_clear_i  in  1  synchronous abort to IDLE
- busy_o  out  1  high from accepted start until done_o/error_o
- done_o  out  1  one-cycle pulse on job completion
- error_o  out  1  one-cycle pulse on acquire retry exhaustion
- job_id_o  out  8  job id returned by acquire; valid from the ACQ_RSP exit until the next start
- req_o  out  1  periph request
- add_o  out  32  byte address
- wen_o  out  1  1 = read, 0 = write
- be_o  out  8  byte enables
- data_o  out  64  write data
- id_o  out  ID_WIDTH  transaction id; constant 0
- gnt_i  in  1  periph grant
- r_data_i  in  64  read data; the low 32 bits are meaningful
- r_valid_i  in  1  response valid
- evt_i  in  1  done event (core 0 evt bit 0)

Behaviour:
- Clocking and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: state IDLE; req_o, busy_o, done_o, error_o = 0; add_o, be_o, data_o, wen_o, job_id_o = 0; retry counter = 0; register index = 0.
- Register map (byte offsets from BASE_ADDR):
  - TRIGGER 0x00
  - ACQUIRE 0x04
  - SOFT_CLEAR 0x14
  - IO regs 0x40 + 4*i
- Lane rule for every access at address A:
  - A[2]=0: be_o = 8'h0F, word placed in data_o[31:0], data_o[63:32] = 0.
  - A[2]=1: be_o = 8'hF0, word placed in data_o[63:32], data_o[31:0] = 0.
  - Reads use the same be_o rule; the returned word is always r_data_i[31:0].
- Handshake:
  - At most one outstanding transaction.
  - Once raised, req_o and add_o/wen_o/be_o/data_o are held stable until the cycle gnt_i=1; that cycle completes the request phase.
  - Reads then wait for r_valid_i (any latency ≥1 cycle).
  - Writes complete on grant; r_valid_i for writes is ignored.
- FSM:
  - IDLE: on start_i, latch job_regs_i, set busy_o, go to ACQ_REQ. start_i is ignored while busy_o=1.
  - ACQ_REQ: read ACQUIRE. On gnt_i, go to ACQ_RSP.
  - ACQ_RSP: on r_valid_i:
    - If r_data_i[31] = 0: job_id_o <= r_data_i[7:0], index <= 0, go to WR_REGS.
    - Else retry+1 and go to ACQ_REQ.
    - If MAX_ACQ_RETRY≠0 and retry reaches MAX_ACQ_RETRY: pulse error_o, clear busy_o, go to IDLE.
  - WR_REGS: write word[index] to 0x40+4*index.
    - On gnt_i, index+1.
    - On gnt_i with index = N_REGS-1, go to TRIGGER.
    - Back-to-back grants give one register per cycle.
  - TRIGGER: write 32'h0 to 0x00. On gnt_i, go to WAIT_EVT.
  - WAIT_EVT: req_o = 0. On evt_i = 1, pulse done_o and clear busy_o in the same cycle, then return to IDLE.
    - evt_i arriving while in any other state is ignored.
- soft_clear_i:
  - Forces IDLE next cycle and clears busy_o, index, retry; no done_o or error_o pulse.
  - A read response arriving later is dropped.
  - soft_clear_i outranks start_i in the same cycle.
- Reset mid-transaction: immediate return to reset values; req_o drops asynchronously.
- Index counter width: $clog2(N_REGS+1). Address arithmetic is 32-bit with wrap.

Decomposition:
- In redmule_pkg:
  - Offset constants REDMULE_TRIGGER_OFS, REDMULE_ACQUIRE_OFS, REDMULE_SOFTCLR_OFS, REDMULE_IO_OFS.
  - A cfg_master_state_e enum.
- One sub-module: redmule_periph_txn.
  - Single-transaction req/gnt/r_valid driver with the lane rule.
  - Inputs: valid, addr, wdata, is_read. Outputs: req_done, rsp_valid, rsp_word.
- The FSM lives in redmule_cfg_master.

Test Plan:
- Immediate grant, acquire returns 0x00000001 → job_id_o = 1; N_REGS writes at 0x40, 0x44, … with be_o alternating 0F/F0; then write 0x00; evt_i after 50 cycles → done_o one pulse, busy_o falls the same cycle.
- Acquire returns 0xFFFFFFFF twice then 0x0 → exactly 3 reads to 0x04, then writes begin; job_id_o = 0.
- Random gnt_i stalls of 0–5 cycles on every access → req_o/add_o/be_o/data_o stable while ungranted; register order and values match job_regs_i.
- MAX_ACQ_RETRY = 3 with acquire always busy → 3 reads, error_o pulse, busy_o = 0, no writes issued.
- soft_clear_i during WR_REGS at index 2 → IDLE next cycle, req_o = 0, no done_o; a new start_i restarts from acquire.
- rst_ni asserted in WAIT_EVT, then evt_i pulsed after release → all outputs 0, no done_o.
